imem_loader: RTL and testbench

Byte-stream program loader that fills the instruction memory before the core runs. It accepts a framed byte stream on a valid/ready handshake and validates the header word count. It writes each payload byte into the instruction memory's byte-wide write port in little-endian order, so byte address 4k holds the LSB of word k. It holds the core in reset via `core_hold` until a load completes cleanly.

---
 rtl/imem_loader.sv | 182 ++++++++++++++++++
 tb/tb_imem_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream loader that fills instruction memory before the core runs.
// Stream frame: one header byte N (word count), then 4*N payload bytes, written
// little-endian starting at byte address 0. core_hold keeps the core in reset
// until a load finishes cleanly.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing checksum byte C
// such that (sum of payload bytes + C) mod 256 must equal 0.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned MEM_WORDS = MEM_BYTES / 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK  = 3'd3,
`endif
    END  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_q, last_d;
  logic               wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [7:0]         wr_data_d;
  logic               core_hold_d;
  logic               done_d;
  logic               error_d;
  logic               accept;
  logic               len_ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
  logic [7:0]         chk_total;
`endif

  // Ready is a pure decode of the state: the loader only listens while framing.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      LEN, DATA: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:       in_ready = 1'b1;
`endif
      default:   in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign len_ok = (in_data != 8'd0) && (32'(in_data) <= MEM_WORDS);
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign chk_total = sum_q + in_data;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and next-value logic for the framing FSM and its datapath.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    core_hold_d = core_hold;
    done_d      = done;
    error_d     = error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      IDLE, END: begin
        if (start) begin
          state_d     = LEN;
          cnt_d       = '0;
          done_d      = 1'b0;
          error_d     = 1'b0;
          core_hold_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      LEN: begin
        if (accept) begin
          if (len_ok) begin
            last_d  = CNT_W'({in_data, 2'b00} - 10'd1);
            state_d = DATA;
          end else begin
            error_d = 1'b1;
            state_d = END;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = in_data;
          cnt_d     = cnt_q + CNT_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d     = sum_q + in_data;
          if (cnt_q == last_q) state_d = CHK;
`else
          if (cnt_q == last_q) begin
            state_d     = END;
            done_d      = 1'b1;
            core_hold_d = 1'b0;
          end
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) begin
          state_d = END;
          if (chk_total == 8'd0) begin
            done_d      = 1'b1;
            core_hold_d = 1'b0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Registered datapath and outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      last_q    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      core_hold <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      wr_en     <= wr_en_d;
      wr_addr   <= wr_addr_d;
      wr_data   <= wr_data_d;
      core_hold <= core_hold_d;
      done      <= done_d;
      error     <= error_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running payload sum for the trailing checksum byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized streams, scoreboard of expected memory writes.
module tb_imem_loader;

  localparam int unsigned MEM_BYTES = 32;
  localparam int unsigned ADDR_W    = 5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              core_hold;
  logic              done;
  logic              error;

  imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_hold(core_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (reset_n && wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%0h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr_data", 32'({wr_addr, wr_data}), 32'({e.a, e.d}));
      end
    end
  end

  // Reference model: expected writes and final outcome of one framed stream.
  function automatic void model(input bq_t s, output bit exp_done);
    int n;
    int sum;
    n = int'(s[0]);
    exp_done = 1'b0;
    sum = 0;
    if (n < 1 || n > int'(MEM_BYTES / 4)) return;
    for (int i = 0; i < 4 * n; i++) begin
      exp_q.push_back({ADDR_W'(i), s[i + 1]});
      sum += int'(s[i + 1]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_done = ((sum + int'(s[4 * n + 1])) % 256) == 0;
`else
    exp_done = 1'b1;
`endif
  endfunction

  // Build a stream with N words; mode picks the checksum: 0 good, 1 bad, 2 random.
  function automatic bq_t make_stream(input int n, input int mode);
    bq_t s;
    int  sum;
    logic [7:0] b;
    s.push_back(8'(n));
    sum = 0;
    if (n >= 1 && n <= int'(MEM_BYTES / 4)) begin
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom);
        s.push_back(b);
        sum += int'(b);
      end
      if (CHK_EN) begin
        if (mode == 0)      s.push_back(8'(256 - (sum % 256)));
        else if (mode == 1) s.push_back(8'(257 - (sum % 256)));
        else                s.push_back(8'($urandom));
      end
    end
    return s;
  endfunction

  // Offer one byte, optionally with random idle gaps, until it is accepted.
  task automatic send(input logic [7:0] b, input bit gaps);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      @(negedge clk); #1;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      #3;
      acc = in_valid && in_ready;
      @(posedge clk);
      guard++;
      if (!acc && guard > 100) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got in_ready=%0b expected a byte accepted within 100 cycles", in_ready);
        return;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); #1;
    start    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_load(input bq_t s, input bit gaps, input bit busy_start, input string tag);
    bit ed;
    bit ok;
    ok = (s[0] != 8'd0) && (int'(s[0]) <= int'(MEM_BYTES / 4));
    model(s, ed);
    pulse_start();
    chk({tag, "_armed_ready"}, 32'(in_ready), 32'(1));
    chk({tag, "_armed_hold"}, 32'({core_hold, done, error}), 32'(3'b100));
    for (int i = 0; i < s.size(); i++) begin
      send(s[i], gaps);
      if (busy_start && i == 2) begin
        @(negedge clk); #1;
        in_valid = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'(ed));
    chk({tag, "_error"}, 32'(error), 32'(!ed));
    chk({tag, "_core_hold"}, 32'(core_hold), 32'(!ed));
    chk({tag, "_last_wr_en"}, 32'(wr_en), 32'(ok && !CHK_EN));
    chk({tag, "_end_ready"}, 32'(in_ready), 32'(0));
  endtask

  initial begin
    bq_t basic;
    bq_t s;
    bit  ed;
    basic = '{8'h02, 8'h33, 8'h03, 8'h94, 8'h00, 8'hb3, 8'h03, 8'h39, 8'h41};

    // Reset values.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_wr", 32'({wr_en, wr_addr, wr_data}), 32'(0));
    chk("rst_flags", 32'({core_hold, done, error}), 32'(3'b100));
    reset_n = 1'b1;

`ifndef IMEM_LOADER_CHECKSUM_EN
    run_load(basic, 1'b0, 1'b0, "basic");
`else
    s = basic;
    s.push_back(8'h06);
    run_load(s, 1'b0, 1'b0, "chk_good");
    s = basic;
    s.push_back(8'h07);
    run_load(s, 1'b0, 1'b0, "chk_bad");
`endif

    // Bad header lengths.
    s = '{8'h00};
    run_load(s, 1'b0, 1'b0, "len00");
    s = '{8'h09};
    run_load(s, 1'b0, 1'b0, "len09");

    // Same basic stream with random valid gaps, and with start pulsed mid-load.
    s = basic;
    if (CHK_EN) s.push_back(8'h06);
    run_load(s, 1'b1, 1'b0, "gaps");
    run_load(s, 1'b0, 1'b1, "busy_start");

    // Randomized loads, including boundary word counts.
    run_load(make_stream(1, 0), 1'b1, 1'b0, "n1");
    run_load(make_stream(8, 0), 1'b1, 1'b0, "n8");
    for (int k = 0; k < 8; k++) begin
      run_load(make_stream(int'($urandom_range(0, 10)), int'($urandom_range(0, 2))), 1'b1, 1'b0, "rand");
    end

    // Reset after the third payload byte, then a clean reload.
    model(basic, ed);
    pulse_start();
    for (int i = 0; i < 4; i++) send(basic[i], 1'b0);
    @(negedge clk); #1;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'(0));
    chk("midrst_wr", 32'({wr_en, wr_addr, wr_data}), 32'(0));
    chk("midrst_flags", 32'({core_hold, done, error}), 32'(3'b100));
    chk("midrst_written", 32'(exp_q.size()), 32'(5));
    exp_q.delete();
    @(negedge clk); #1;
    reset_n = 1'b1;
    s = basic;
    if (CHK_EN) s.push_back(8'h06);
    run_load(s, 1'b0, 1'b0, "reload");

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
